imem_loader: RTL

//  Write-side companion to the instruction memory. Accepts a byte stream from a host link
//  (UART RX or testbench), assembles little-endian 32-bit words and issues one write per

---
 rtl/imem_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words from a host link and writes
// them into instruction memory, holding the core in reset until a load completes.
module imem_loader #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 512,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            wr_en,
  output logic [XLEN-1:0] wr_addr,
  output logic [31:0]     wr_data,
  output logic            core_rst,
  output logic            busy,
  output logic            done,
  output logic            error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        xfer;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [15:0] len_rx;
  logic [15:0] word_idx_q;
  logic [15:0] word_nxt;
  logic [1:0]  byte_cnt_q;
  logic [23:0] buf_q;

  logic rx_ready_d, wr_en_d, busy_d, done_d, error_d, core_rst_d;

  function automatic logic [XLEN-1:0] word_addr(input logic [15:0] idx);
    return BASE_ADDR + XLEN'({idx, 2'b00});
  endfunction

  assign xfer     = rx_valid && rx_ready;
  assign len_rx   = {rx_data, len_lo_q};
  assign word_nxt = word_idx_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rx_ready <= 1'b0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      state_q  <= state_d;
      rx_ready <= rx_ready_d;
      wr_en    <= wr_en_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
      core_rst <= core_rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (xfer) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (len_rx == 16'd0)                 state_d = S_DONE;
          else if (32'(len_rx) > DEPTH_WORDS)  state_d = S_ERR;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA:  if (xfer && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = (word_nxt == len_q) ? S_DONE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they line up with state_q.
  always_comb begin
    rx_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
    wr_en_d    = (state_d == S_WRITE);
    busy_d     = rx_ready_d || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    core_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            word_idx_q <= '0;
            byte_cnt_q <= '0;
          end
        end
        S_LEN_LO: if (xfer) len_lo_q <= rx_data;
        S_LEN_HI: if (xfer) len_q <= len_rx;
        S_DATA: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wr_data <= {rx_data, buf_q};
              wr_addr <= word_addr(word_idx_q);
            end
          end
        end
        S_WRITE: word_idx_q <= word_nxt;
        default: ;
      endcase
    end
  end

  // Lower three bytes of the word under assembly; the top byte goes straight to wr_data.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && xfer && byte_cnt_q != 2'd3)
      buf_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
  end

endmodule
